cpu4_uart_tx: RTL and testbench
===============================

// Module: cpu4_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter on the cpu4 core's data-store bus, beside cpu4_ram.
//  Consumes dataadr/writedata/memwrite, decodes a 2-word window and buffers bytes in a small FIFO.
//  Serialises each byte as 8N1 on txd. Exposes a status word that top muxes onto readdata when sel=1.
// PARAMETERS
//  BASE_ADDR     32'h0000_0100  word address of TXDATA; STATUS is at BASE_ADDR+4
//  CLKS_PER_BIT  16             clk cycles per serial bit, >=2
//  FIFO_DEPTH    4              byte entries, power of 2, >=2
// PORTS
//  clk        in   1   single clock, all state updates on posedge
//  reset      in   1   synchronous, active-high
//  dataadr    in   32  core data address
//  writedata  in   32  core store data
//  memwrite   in   1   core store strobe, one cycle per store
//  sel        out  1   dataadr == BASE_ADDR or BASE_ADDR+4; combinational
//  rdata      out  32  read data for the window; 0 when sel=0; combinational
//  txd        out  1   serial line, idle high, registered
//  busy       out  1   FIFO non-empty or frame in progress
//  overflow   out  1   sticky: a push was dropped because the FIFO was full
// BEHAVIOUR
//  Reset: FIFO empty, state IDLE, txd=1, busy=0, overflow=0. Reset mid-frame aborts the frame.
//   txd is 1 after that edge and FIFO contents are discarded.
//  Push: memwrite && dataadr==BASE_ADDR -> writedata[7:0] enters the FIFO at the edge. Upper bits are ignored.
//  Full: the push is dropped, FIFO is unchanged and overflow<=1.
//   Full + push + pop in the same cycle -> push accepted, no overflow.
//  Clear: memwrite && dataadr==BASE_ADDR+4 && writedata[2] -> overflow<=0. Other bits are ignored.
//  Read: BASE_ADDR reads 0. BASE_ADDR+4 reads {29'b0, overflow, full, busy}.
//   Reads have no side effects.
//  FSM states: IDLE, START, DATA, STOP. A bit counter counts down from CLKS_PER_BIT-1.
//   A 3-bit index selects the bit.
//   IDLE:  FIFO non-empty -> pop to shift reg, go to START, txd<=0. Else txd stays 1.
//   START: hold txd=0 for CLKS_PER_BIT cycles, then DATA with bit 0.
//   DATA:  8 bits LSB first, each CLKS_PER_BIT cycles. After bit 7 -> STOP, txd<=1.
//   STOP:  txd=1 for CLKS_PER_BIT cycles. At the end: FIFO non-empty -> pop and go to START directly, no gap.
//     Else go to IDLE.
//  Latency: push at edge N into an idle, empty block -> IDLE sees non-empty -> txd=0 after edge N+1.
//   Frame length is exactly 10*CLKS_PER_BIT cycles. Back-to-back frames have zero idle cycles.
//  A push and a pop in the same cycle on an empty FIFO cannot happen: the pop needs non-empty at the prior edge.
//  FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. full/empty come from the MSB compare.
// STRUCTURE
//  defines.v: `UART_TX_IDLE/START/DATA/STOP 2-bit encodings, `UART_ST_BUSY/FULL/OVF bit indices.
//  Sub-module cpu4_sync_fifo (WIDTH=8, DEPTH): push, pop, din, dout (show-ahead), full, empty.
//   Same clk and synchronous reset.
//  The top-level adds cpu4_uart_tx and muxes readdata = sel ? rdata : ram readdata.
//   Only memwrite&&!sel reaches the RAM.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=0x100)
//  1 Reset: after reset, txd=1, busy=0, overflow=0, and a read at 0x104 gives 0.
//  2 Single byte: store 0xA5 to 0x100.
//    txd=0 for 4 cycles from edge N+1.
//    Then the data bits 1,0,1,0,0,1,0,1 (LSB first), 4 cycles each.
//    Then txd=1 for 4 cycles, busy=0 after 40 cycles.
//  3 Back-to-back: store 0x55 then 0x0F on consecutive cycles.
//    The 0x0F start bit follows the 0x55 stop bit with no gap. Total busy 80 cycles.
//  4 Overflow: while the first frame is shifting, do 5 more stores (FIFO holds 4).
//    overflow=1 and status reads 0x7. Only 5 frames are sent.
//    Store 0x4 to 0x104 -> overflow=0.
//  5 Reset mid-frame: assert reset during DATA bit 3.
//    txd=1 next edge, busy=0, and no further frames are sent.
//  6 Decode: a store to 0x108 or 0x0FC is ignored, sel=0 and rdata=0. A store to 0x101 is not a push.

Source files
------------

// File: rtl/cpu4_uart_tx_pkg.sv
// Shared types and constants for the cpu4 memory-mapped UART transmitter.
//  - tx_state_e : serialiser FSM states
//  - St*Bit     : bit positions inside the STATUS word
package cpu4_uart_tx_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  localparam int unsigned StBusyBit = 0;
  localparam int unsigned StFullBit = 1;
  localparam int unsigned StOvfBit  = 2;

endpackage

// File: rtl/cpu4_sync_fifo.sv
// Synchronous show-ahead FIFO.
//  clk, reset   : single clock, synchronous active-high reset (empties the FIFO)
//  push, din    : write request and data; ignored when full unless a pop happens the same cycle
//  pop          : read request; ignored when empty
//  dout         : head entry, valid whenever empty=0
//  full, empty  : occupancy flags
module cpu4_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees a slot in the same cycle, so a push on a full FIFO is accepted then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cpu4_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the cpu4 data-store bus.
//  clk, reset         : single clock, synchronous active-high reset
//  dataadr, writedata : core store address / data
//  memwrite           : one-cycle store strobe
//  sel                : address hits TXDATA (BASE_ADDR) or STATUS (BASE_ADDR+4)
//  rdata              : window read data, STATUS = {29'b0, overflow, full, busy}
//  txd                : registered serial output, idle high
//  busy               : FIFO non-empty or a frame in progress
//  overflow           : sticky, set when a push was dropped; cleared by STATUS write with bit 2
module cpu4_uart_tx
  import cpu4_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  input  logic        memwrite,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned   CntW       = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLoad  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [31:0]   StatusAddr = BASE_ADDR + 32'd4;

  tx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [2:0]      idx_next;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;
  logic            overflow_q, overflow_d;

  logic            push_req, clr_req, pop;
  logic [7:0]      fifo_dout;
  logic            fifo_full, fifo_empty;

  logic            unused_wdata;
  assign unused_wdata = ^writedata[31:8];

  assign sel      = (dataadr == BASE_ADDR) || (dataadr == StatusAddr);
  assign push_req = memwrite && (dataadr == BASE_ADDR);
  assign clr_req  = memwrite && (dataadr == StatusAddr) && writedata[2];

  cpu4_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (writedata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign busy     = !fifo_empty || (state_q != StIdle);
  assign overflow = overflow_q;
  assign txd      = txd_q;

  always_comb begin
    rdata = '0;
    if (dataadr == StatusAddr) begin
      rdata[StBusyBit] = busy;
      rdata[StFullBit] = fifo_full;
      rdata[StOvfBit]  = overflow_q;
    end
  end

  // Push and clear never coincide: they decode different addresses.
  always_comb begin
    overflow_d = overflow_q;
    if (push_req && fifo_full && !pop) overflow_d = 1'b1;
    if (clr_req) overflow_d = 1'b0;
  end

  assign idx_next = idx_q + 3'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          cnt_d   = CntLoad;
          txd_d   = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == '0) begin
          cnt_d   = CntLoad;
          idx_d   = 3'd0;
          txd_d   = shift_q[0];
          state_d = StData;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          cnt_d = CntLoad;
          if (idx_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = StStop;
          end else begin
            idx_d = idx_next;
            txd_d = shift_q[idx_next];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == '0) begin
          // Chain straight into the next start bit so queued bytes go out gap-free.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            cnt_d   = CntLoad;
            txd_d   = 1'b0;
            state_d = StStart;
          end else begin
            txd_d   = 1'b1;
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_cpu4_uart_tx.sv
module tb_cpu4_uart_tx;

  localparam int C     = 4;
  localparam int FRAME = 10 * C;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic        memwrite = 1'b0;
  logic        sel;
  logic [31:0] rdata;
  logic        txd, busy, overflow;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  // Serial receiver model: decodes frames off txd by sampling mid-bit.
  logic [7:0] rx_q[$];
  int         framing_err = 0;
  bit         mon_active = 0;
  int         mon_idx = 0;
  logic [7:0] mon_byte = '0;
  logic       mon_rst = 1'b0;

  cpu4_uart_tx #(
    .BASE_ADDR    (32'h0000_0100),
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dataadr   (dataadr),
    .writedata (writedata),
    .memwrite  (memwrite),
    .sel       (sel),
    .rdata     (rdata),
    .txd       (txd),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    mon_rst = reset;
    #1;
    if (mon_rst) begin
      mon_active = 0;
    end else if (!mon_active) begin
      if (txd === 1'b0) begin
        mon_active = 1;
        mon_idx = 0;
      end
    end else begin
      mon_idx++;
      if (mon_idx == C / 2 && txd !== 1'b0) begin
        framing_err++;
        mon_active = 0;
      end else if (mon_idx % C == C / 2 && mon_idx / C >= 1 && mon_idx / C <= 8) begin
        mon_byte[mon_idx / C - 1] = txd;
      end else if (mon_idx == 9 * C + C / 2) begin
        if (txd !== 1'b1) framing_err++;
        else rx_q.push_back(mon_byte);
      end else if (mon_idx == FRAME - 1) begin
        mon_active = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    dataadr   = a;
    writedata = d;
    memwrite  = 1'b1;
    tick();
    memwrite  = 1'b0;
    dataadr   = '0;
    writedata = '0;
  endtask

  // Expected line level for bit k (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tests_run++;
    if (txd !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: txd=%b busy=%b ovf=%b, want 1 0 0", txd, busy, overflow);
    end
    reset = 1'b0;
    dataadr = 32'h104;
    #1;
    tests_run++;
    if (rdata !== 32'h0 || sel !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_status: rdata=%h sel=%b, want 0 1", rdata, sel);
    end
    dataadr = 32'h100;
    #1;
    tests_run++;
    if (rdata !== 32'h0 || sel !== 1'b1) begin
      tests_failed++;
      $display("FAIL txdata_read: rdata=%h sel=%b, want 0 1", rdata, sel);
    end
    dataadr = '0;
    tick();
  endtask

  task automatic test_single();
    rx_q.delete();
    store(32'h100, 32'hFFFF_FFA5);
    tests_run++;
    if (busy !== 1'b1 || txd !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_push_edge: busy=%b txd=%b, want 1 1", busy, txd);
    end
    tick();
    for (int k = 0; k < FRAME; k++) begin
      tests_run++;
      if (txd !== frame_bit(8'hA5, k / C) || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL single_wave cyc %0d: txd=%b busy=%b, want %b 1",
                 k, txd, busy, frame_bit(8'hA5, k / C));
      end
      tick();
    end
    tests_run++;
    if (busy !== 1'b0 || txd !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_end: busy=%b txd=%b, want 0 1", busy, txd);
    end
    tests_run++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
      tests_failed++;
      $display("FAIL single_rx: got %0d bytes, want 1 byte a5", rx_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    rx_q.delete();
    store(32'h100, 32'h55);
    store(32'h100, 32'h0F);
    for (int k = 0; k < 2 * FRAME; k++) begin
      b = (k < FRAME) ? 8'h55 : 8'h0F;
      tests_run++;
      if (txd !== frame_bit(b, (k % FRAME) / C) || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_wave cyc %0d: txd=%b busy=%b, want %b 1",
                 k, txd, busy, frame_bit(b, (k % FRAME) / C));
      end
      tick();
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_end: busy=%b, want 0", busy);
    end
    tests_run++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h55 || rx_q[1] !== 8'h0F) begin
      tests_failed++;
      $display("FAIL b2b_rx: got %0d bytes, want 55 0f", rx_q.size());
    end
  endtask

  task automatic test_decode();
    logic [31:0] addrs[3];
    addrs[0] = 32'h108;
    addrs[1] = 32'h0FC;
    addrs[2] = 32'h101;
    rx_q.delete();
    for (int i = 0; i < 3; i++) begin
      dataadr   = addrs[i];
      writedata = 32'h5E;
      memwrite  = 1'b1;
      #1;
      tests_run++;
      if (sel !== 1'b0 || rdata !== 32'h0) begin
        tests_failed++;
        $display("FAIL decode_%h: sel=%b rdata=%h, want 0 0", addrs[i], sel, rdata);
      end
      tick();
      memwrite = 1'b0;
    end
    dataadr = '0;
    writedata = '0;
    repeat (60) tick();
    tests_run++;
    if (busy !== 1'b0 || rx_q.size() != 0) begin
      tests_failed++;
      $display("FAIL decode_nopush: busy=%b frames=%0d, want 0 0", busy, rx_q.size());
    end
  endtask

  task automatic test_overflow();
    int budget;
    rx_q.delete();
    store(32'h100, 32'hA1);
    for (int i = 0; i < 5; i++) store(32'h100, 32'hB0 + i);
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_set: overflow=%b, want 1", overflow);
    end
    dataadr = 32'h104;
    #1;
    tests_run++;
    if (rdata !== 32'h7 || sel !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_status: rdata=%h sel=%b, want 7 1", rdata, sel);
    end
    dataadr = '0;
    budget = 0;
    while ((rx_q.size() < 5 || busy) && budget < 600) begin
      tick();
      budget++;
    end
    repeat (60) tick();
    tests_run++;
    if (rx_q.size() != 5) begin
      tests_failed++;
      $display("FAIL ovf_frames: got %0d frames, want 5", rx_q.size());
    end else begin
      tests_run++;
      if (rx_q[0] !== 8'hA1 || rx_q[1] !== 8'hB0 || rx_q[2] !== 8'hB1 ||
          rx_q[3] !== 8'hB2 || rx_q[4] !== 8'hB3) begin
        tests_failed++;
        $display("FAIL ovf_bytes: got %h %h %h %h %h, want a1 b0 b1 b2 b3",
                 rx_q[0], rx_q[1], rx_q[2], rx_q[3], rx_q[4]);
      end
    end
    store(32'h104, 32'hFB);
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_noclear: overflow=%b, want 1", overflow);
    end
    store(32'h104, 32'h4);
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_clear: overflow=%b, want 0", overflow);
    end
  endtask

  task automatic test_reset_mid_frame();
    rx_q.delete();
    store(32'h100, 32'h34);
    store(32'h100, 32'h81);
    // Frame began at the edge just passed; land inside data bit 3 (frame bit 4).
    repeat (4 * C + 1) tick();
    tests_run++;
    if (txd !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_pre: txd=%b, want 0 (data bit 3 of 34)", txd);
    end
    reset = 1'b1;
    tick();
    tests_run++;
    if (txd !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_abort: txd=%b busy=%b ovf=%b, want 1 0 0", txd, busy, overflow);
    end
    reset = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      tests_run++;
      if (txd !== 1'b1 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL midreset_idle cyc %0d: txd=%b busy=%b, want 1 0", k, txd, busy);
      end
    end
    tests_run++;
    if (rx_q.size() != 0) begin
      tests_failed++;
      $display("FAIL midreset_frames: got %0d frames, want 0", rx_q.size());
    end
  endtask

  // Timing-level model: each accepted byte starts at max(push edge + 1, previous start + FRAME);
  // a byte sits in the FIFO until its start edge, and a push on a full FIFO survives only if a
  // start happens on that same edge.
  task automatic test_random();
    logic [7:0] exp_q[$];
    int         starts[$];
    int         last_start;
    bit         exp_ovf;
    int         t, pending, gap, st, budget;
    bit         pop_now;
    logic [7:0] d;
    rx_q.delete();
    last_start = -100000;
    exp_ovf = 0;
    for (int i = 0; i < 16; i++) begin
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 90) : $urandom_range(0, 3);
      repeat (gap) tick();
      d = 8'($urandom);
      store(32'h100, {24'($urandom), d});
      t = cyc;
      pending = 0;
      pop_now = 0;
      foreach (starts[j]) begin
        if (starts[j] >= t) pending++;
        if (starts[j] == t) pop_now = 1;
      end
      if (pending < DEPTH || pop_now) begin
        st = (t + 1 > last_start + FRAME) ? t + 1 : last_start + FRAME;
        starts.push_back(st);
        exp_q.push_back(d);
        last_start = st;
      end else begin
        exp_ovf = 1;
      end
    end
    budget = 0;
    while ((rx_q.size() < exp_q.size() || busy) && budget < 1500) begin
      tick();
      budget++;
    end
    repeat (50) tick();
    tests_run++;
    if (rx_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL rand_count: got %0d frames, want %0d", rx_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[j]) begin
        tests_run++;
        if (rx_q[j] !== exp_q[j]) begin
          tests_failed++;
          $display("FAIL rand_byte %0d: got %h, want %h", j, rx_q[j], exp_q[j]);
        end
      end
    end
    tests_run++;
    if (overflow !== exp_ovf) begin
      tests_failed++;
      $display("FAIL rand_overflow: overflow=%b, want %b", overflow, exp_ovf);
    end
    tests_run++;
    if (framing_err != 0) begin
      tests_failed++;
      $display("FAIL framing: %0d bad frames seen, want 0", framing_err);
    end
    store(32'h104, 32'h4);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_decode();
    test_overflow();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
